qp_mem_arbiter: RTL and testbench
=================================

QP_MEM_ARBITER -- requirements
Module: qp_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, patch element width in bits.
REQ-002 SHALL have parameter PATCH_SIZE, default 5, elements per patch; PW = DATA_WIDTH*PATCH_SIZE (55).
REQ-003 SHALL have parameter ADDR_W, default 9, query-patch memory address width.
REQ-004 SHALL have parameter STARVE_MAX, default 8, accelerator wait limit in cycles.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with these ports:
- wb_clk_i  in  1  clock, all state on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_mode  in  1  1 = Wishbone-priority mode, 0 = round-robin mode
- wbs_req, acc_req  in  1  access request (Wishbone side, accelerator side)
- wbs_we, acc_we  in  1  1 = write, 0 = read
- wbs_addr, acc_addr  in  ADDR_W  patch address
- wbs_wdata, acc_wdata  in  PW  write patch
- wbs_gnt, acc_gnt  out  1  access accepted this cycle
- wbs_rvalid, acc_rvalid  out  1  read data valid
- wbs_rdata, acc_rdata  out  PW  read patch
- mem_csb0  out  1  SRAM chip select, active-low
- mem_web0  out  1  SRAM write enable, active-low
- mem_addr0  out  ADDR_W  SRAM address
- mem_wpatch0  out  PW  SRAM write data
- mem_rpatch0  in  PW  SRAM read data, valid one cycle after a read command

Function
REQ-006 SHALL evaluate arbitration combinationally in cycle T; at most one of wbs_gnt/acc_gnt is high in any cycle.
REQ-007 Requesters SHALL hold req/we/addr/wdata stable until gnt; a requester may present a new request in the cycle after gnt (back-to-back, one access per cycle).
REQ-008 In wbs_mode=1, wbs_req SHALL win, unless the starvation counter equals STARVE_MAX and acc_req is high, in which case acc SHALL win.
REQ-009 The starvation counter (width clog2(STARVE_MAX+1)):
- increments while acc_req=1 and acc is not granted, saturating at STARVE_MAX
- clears on acc_gnt, or when acc_req=0
REQ-010 In wbs_mode=0, a single requester SHALL be granted immediately; on a tie, the side not granted last SHALL win.
REQ-011 A 1-bit last-granted pointer SHALL update on every grant in both modes; after reset it points to acc, so Wishbone wins the first tie.
REQ-012 Changing wbs_mode SHALL take effect on the next arbitration cycle, without flushing accesses already in flight.
REQ-013 Command outputs SHALL be registered; a grant in cycle T drives the SRAM in cycle T+1:
- mem_csb0 = 0
- mem_web0 = ~we
- mem_addr0 = addr
- mem_wpatch0 = wdata
REQ-014 With no grant in cycle T, cycle T+1 SHALL drive mem_csb0=1, mem_web0=1; addr and wpatch hold their previous values.
REQ-015 A read granted in cycle T SHALL raise the owner's rvalid for exactly one cycle in T+2, with rdata = mem_rpatch0 (passthrough).
REQ-016 A two-stage owner/valid pipeline SHALL carry read tags; rvalid SHALL never go to the non-owner, and writes produce no rvalid.
REQ-017 wbs_rdata and acc_rdata SHALL both mirror mem_rpatch0; only rvalid qualifies them.
REQ-018 Total latency SHALL be 2 cycles from gnt to rvalid; sustained throughput SHALL be 1 access per cycle across both requesters.

Reset
REQ-019 While wb_rst_i=1, asynchronously:
- mem_csb0=1, mem_web0=1, mem_addr0=0, mem_wpatch0=0
- gnt and rvalid outputs = 0
- starvation counter = 0, pointer = acc
- read pipeline cleared
REQ-020 Reads in flight when reset asserts SHALL be dropped; no rvalid SHALL appear after reset release for a pre-reset grant.
REQ-021 Grants SHALL be suppressed while wb_rst_i=1; arbitration resumes on the first rising edge after deassertion.

Verification
REQ-022 Reset release, wbs read addr 1, mem_rpatch0=55'h00_1010_DEAD_BEEF at T+2 -> wbs_gnt at T; T+1 csb0=0, web0=1, addr0=1; wbs_rvalid=1 at T+2 with that data; acc_rvalid=0.
REQ-023 acc write addr 2, wdata=55'h0B_CDEF_0123_4567 -> acc_gnt at T; T+1 csb0=0, web0=0, addr0=2, wpatch0 matches; no rvalid.
REQ-024 wbs_mode=0, both sides request reads continuously -> grants alternate wbs, acc, wbs, acc; rvalid alternates 2 cycles later, each with the correct owner.
REQ-025 wbs_mode=1, both sides request continuously -> wbs granted 8 cycles, acc granted on the 9th, pattern repeats; counter clears after the acc grant.
REQ-026 wb_rst_i pulsed one cycle after a wbs read grant -> csb0=1 immediately; no wbs_rvalid in the following 3 cycles.
REQ-027 Idle (no requests) for 5 cycles -> csb0=1 and web0=1 throughout; no gnt or rvalid.

Source files
------------

// File: rtl/qp_mem_arbiter.sv
// Two-port arbiter sharing one single-port query-patch SRAM between Wishbone and the accelerator.
// Grants are combinational; the SRAM command is registered and read data returns two cycles after grant.
module qp_mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned PATCH_SIZE = 5,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_i,
  input  logic                               wbs_mode,
  input  logic                               wbs_req,
  input  logic                               wbs_we,
  input  logic [ADDR_W-1:0]                  wbs_addr,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0]   wbs_wdata,
  output logic                               wbs_gnt,
  output logic                               wbs_rvalid,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0]   wbs_rdata,
  input  logic                               acc_req,
  input  logic                               acc_we,
  input  logic [ADDR_W-1:0]                  acc_addr,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0]   acc_wdata,
  output logic                               acc_gnt,
  output logic                               acc_rvalid,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0]   acc_rdata,
  output logic                               mem_csb0,
  output logic                               mem_web0,
  output logic [ADDR_W-1:0]                  mem_addr0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0]   mem_wpatch0,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0]   mem_rpatch0
);

  localparam int unsigned PW = DATA_WIDTH * PATCH_SIZE;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          last_acc_q, last_acc_d;
  logic          csb_q, csb_d;
  logic          web_q, web_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0] wpatch_q, wpatch_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_own_acc_q, rd_own_acc_d;
  logic          wbs_rv_q, wbs_rv_d;
  logic          acc_rv_q, acc_rv_d;

  logic          starved_c;
  logic          gnt_wbs_c, gnt_acc_c;
  logic          grant_c;
  logic          sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [PW-1:0] sel_wdata_c;

  assign starved_c = (starve_q == SW'(STARVE_MAX));

  // Arbitration: priority mode with starvation escape, or fair round-robin.
  always_comb begin
    gnt_wbs_c = 1'b0;
    gnt_acc_c = 1'b0;
    if (!wb_rst_i) begin
      if (wbs_mode) begin
        if (acc_req && (starved_c || !wbs_req)) begin
          gnt_acc_c = 1'b1;
        end else if (wbs_req) begin
          gnt_wbs_c = 1'b1;
        end
      end else begin
        if (wbs_req && acc_req) begin
          gnt_wbs_c = last_acc_q;
          gnt_acc_c = !last_acc_q;
        end else begin
          gnt_wbs_c = wbs_req;
          gnt_acc_c = acc_req;
        end
      end
    end
  end

  assign grant_c     = gnt_wbs_c | gnt_acc_c;
  assign sel_we_c    = gnt_acc_c ? acc_we    : wbs_we;
  assign sel_addr_c  = gnt_acc_c ? acc_addr  : wbs_addr;
  assign sel_wdata_c = gnt_acc_c ? acc_wdata : wbs_wdata;

  // Next state for arbitration bookkeeping, SRAM command and read-tag pipeline.
  always_comb begin
    starve_d     = starve_q;
    last_acc_d   = last_acc_q;
    csb_d        = 1'b1;
    web_d        = 1'b1;
    addr_d       = addr_q;
    wpatch_d     = wpatch_q;
    rd_vld_d     = 1'b0;
    rd_own_acc_d = 1'b0;
    wbs_rv_d     = rd_vld_q & ~rd_own_acc_q;
    acc_rv_d     = rd_vld_q &  rd_own_acc_q;

    if (!acc_req || gnt_acc_c) begin
      starve_d = '0;
    end else if (!starved_c) begin
      starve_d = starve_q + SW'(1);
    end

    if (grant_c) begin
      last_acc_d   = gnt_acc_c;
      csb_d        = 1'b0;
      web_d        = ~sel_we_c;
      addr_d       = sel_addr_c;
      wpatch_d     = sel_wdata_c;
      rd_vld_d     = ~sel_we_c;
      rd_own_acc_d = gnt_acc_c;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      starve_q     <= '0;
      last_acc_q   <= 1'b1;
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      addr_q       <= '0;
      wpatch_q     <= '0;
      rd_vld_q     <= 1'b0;
      rd_own_acc_q <= 1'b0;
      wbs_rv_q     <= 1'b0;
      acc_rv_q     <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      last_acc_q   <= last_acc_d;
      csb_q        <= csb_d;
      web_q        <= web_d;
      addr_q       <= addr_d;
      wpatch_q     <= wpatch_d;
      rd_vld_q     <= rd_vld_d;
      rd_own_acc_q <= rd_own_acc_d;
      wbs_rv_q     <= wbs_rv_d;
      acc_rv_q     <= acc_rv_d;
    end
  end

  assign wbs_gnt     = gnt_wbs_c;
  assign acc_gnt     = gnt_acc_c;
  assign mem_csb0    = csb_q;
  assign mem_web0    = web_q;
  assign mem_addr0   = addr_q;
  assign mem_wpatch0 = wpatch_q;
  assign wbs_rvalid  = wbs_rv_q;
  assign acc_rvalid  = acc_rv_q;
  // Read data is shared by both sides; rvalid alone identifies the owner.
  assign wbs_rdata   = mem_rpatch0;
  assign acc_rdata   = mem_rpatch0;

endmodule

// File: tb/tb_qp_mem_arbiter.sv
// Scoreboard bench for qp_mem_arbiter: stimulus queues expected grants, SRAM commands and
// read returns; a negedge monitor pops and compares whenever the DUT presents one.
module tb_qp_mem_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned PW = 55;

  logic          clk = 1'b0;
  logic          rst;
  logic          wbs_mode;
  logic          wbs_req, wbs_we, acc_req, acc_we;
  logic [AW-1:0] wbs_addr, acc_addr;
  logic [PW-1:0] wbs_wdata, acc_wdata;
  logic          wbs_gnt, acc_gnt, wbs_rvalid, acc_rvalid;
  logic [PW-1:0] wbs_rdata, acc_rdata;
  logic          mem_csb0, mem_web0;
  logic [AW-1:0] mem_addr0;
  logic [PW-1:0] mem_wpatch0;
  logic [PW-1:0] mem_rpatch0 = '0;

  qp_mem_arbiter #(
    .DATA_WIDTH(11), .PATCH_SIZE(5), .ADDR_W(9), .STARVE_MAX(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_mode(wbs_mode),
    .wbs_req(wbs_req), .wbs_we(wbs_we), .wbs_addr(wbs_addr), .wbs_wdata(wbs_wdata),
    .wbs_gnt(wbs_gnt), .wbs_rvalid(wbs_rvalid), .wbs_rdata(wbs_rdata),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0),
    .mem_wpatch0(mem_wpatch0), .mem_rpatch0(mem_rpatch0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Address 1 returns the reference patch 55'h00_1010_DEAD_BEEF.
  function automatic logic [PW-1:0] patch_of(input logic [AW-1:0] a);
    return 55'h00_1010_DEAD_BEEF ^ PW'(a ^ 9'd1);
  endfunction

  // SRAM model: read data appears the cycle after a read command.
  always @(posedge clk) begin
    if (!mem_csb0 && mem_web0) mem_rpatch0 <= patch_of(mem_addr0);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic          side;
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } exp_t;

  exp_t gnt_q[$];
  exp_t cmd_q[$];
  exp_t rv_q[$];

  task automatic expect_gnt(input logic side);
    exp_t e;
    e.side = side; e.cyc = cyc; e.we = 1'b0; e.addr = '0; e.data = '0;
    gnt_q.push_back(e);
  endtask

  // Full access: grant now, SRAM command next cycle, read return two cycles out.
  task automatic expect_acc(input logic side, input logic we, input logic [AW-1:0] addr,
                            input logic [PW-1:0] wd);
    exp_t e;
    expect_gnt(side);
    e.side = side; e.cyc = cyc + 1; e.we = we; e.addr = addr; e.data = wd;
    cmd_q.push_back(e);
    if (!we) begin
      e.cyc  = cyc + 2;
      e.data = patch_of(addr);
      rv_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wbs_req = 1'b0; acc_req = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (wbs_gnt || acc_gnt) begin
      chk("gnt_onehot", 64'(wbs_gnt & acc_gnt), 64'd0);
      if (gnt_q.size() == 0) begin
        chk("gnt_unexpected", {31'd0, acc_gnt, 32'(cyc)}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = gnt_q.pop_front();
        chk("gnt", {31'd0, acc_gnt, 32'(cyc)}, {31'd0, e.side, 32'(e.cyc)});
      end
    end
    if (!mem_csb0) begin
      if (cmd_q.size() == 0) begin
        chk("cmd_unexpected", {22'd0, mem_web0, mem_addr0, 32'(cyc)}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = cmd_q.pop_front();
        chk("cmd", {22'd0, mem_web0, mem_addr0, 32'(cyc)}, {22'd0, ~e.we, e.addr, 32'(e.cyc)});
        if (e.we) chk("cmd_wdata", 64'(mem_wpatch0), 64'(e.data));
      end
    end
    if (wbs_rvalid || acc_rvalid) begin
      chk("rv_onehot", 64'(wbs_rvalid & acc_rvalid), 64'd0);
      if (rv_q.size() == 0) begin
        chk("rv_unexpected", {31'd0, acc_rvalid, 32'(cyc)}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = rv_q.pop_front();
        chk("rv", {31'd0, acc_rvalid, 32'(cyc)}, {31'd0, e.side, 32'(e.cyc)});
        chk("rv_data", 64'(acc_rvalid ? acc_rdata : wbs_rdata), 64'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1; wbs_mode = 1'b1;
    wbs_req = 1'b1; wbs_we = 1'b0; wbs_addr = '0; wbs_wdata = '0;
    acc_req = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0;

    // Reset state, with a pending request that must not be granted.
    @(negedge clk);
    chk("rst_csb_web", 64'({mem_csb0, mem_web0}), 64'd3);
    chk("rst_addr", 64'(mem_addr0), 64'd0);
    chk("rst_wpatch", 64'(mem_wpatch0), 64'd0);
    chk("rst_gnt", 64'({wbs_gnt, acc_gnt}), 64'd0);
    chk("rst_rvalid", 64'({wbs_rvalid, acc_rvalid}), 64'd0);
    step(); rst = 1'b0; idle();

    // Wishbone read of address 1.
    step(); wbs_req = 1'b1; wbs_we = 1'b0; wbs_addr = 9'd1;
    expect_acc(1'b0, 1'b0, 9'd1, '0);
    step(); idle();

    // Accelerator write of address 2.
    step(); acc_req = 1'b1; acc_we = 1'b1; acc_addr = 9'd2; acc_wdata = 55'h0B_CDEF_0123_4567;
    expect_acc(1'b1, 1'b1, 9'd2, 55'h0B_CDEF_0123_4567);
    step(); idle();
    step();

    // Round-robin with both sides reading continuously; last grant was acc so wbs leads.
    for (int i = 0; i < 6; i++) begin
      step();
      wbs_mode = 1'b0;
      wbs_req = 1'b1; wbs_we = 1'b0; wbs_addr = 9'h10 + 9'((i + 1) / 2);
      acc_req = 1'b1; acc_we = 1'b0; acc_addr = 9'h20 + 9'(i / 2);
      if (i % 2 == 0) expect_acc(1'b0, 1'b0, wbs_addr, '0);
      else            expect_acc(1'b1, 1'b0, acc_addr, '0);
    end
    step(); idle();

    // Wishbone priority: eight wbs grants, then the starved accelerator, repeated.
    for (int i = 0; i < 18; i++) begin
      step();
      wbs_mode = 1'b1;
      wbs_req = 1'b1; wbs_we = 1'b0; wbs_addr = 9'h40 + 9'(i - i / 9);
      acc_req = 1'b1; acc_we = 1'b1; acc_addr = 9'h80 + 9'(i / 9);
      acc_wdata = patch_of(acc_addr) ^ 55'h7FF;
      if (i % 9 == 8) expect_acc(1'b1, 1'b1, acc_addr, acc_wdata);
      else            expect_acc(1'b0, 1'b0, wbs_addr, '0);
    end
    step(); idle();
    step(); step();

    // Reset pulse right after a read grant drops the read.
    step(); wbs_req = 1'b1; wbs_we = 1'b0; wbs_addr = 9'd3;
    expect_gnt(1'b0);
    step(); wbs_addr = 9'd4; rst = 1'b1;
    #1;
    chk("rst_pulse_csb", 64'(mem_csb0), 64'd1);
    chk("rst_pulse_gnt", 64'({wbs_gnt, acc_gnt}), 64'd0);
    step(); rst = 1'b0; idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_drop_rvalid", 64'({wbs_rvalid, acc_rvalid}), 64'd0);
    end

    // Idle: no commands, grants or read returns.
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      chk("idle", 64'({mem_csb0, mem_web0, wbs_gnt, acc_gnt, wbs_rvalid, acc_rvalid}), 64'h30);
    end

    step(); step();
    chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    chk("rv_q_drained", 64'(rv_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
